regbank_scoreboard: RTL and testbench

Parametrised successor to the 16x32 register bank used by the datapath. It adds:
- configurable width and depth;
- an asynchronous reset that loads deterministic init values;
- an optional hardwired-zero R0;
- a per-register pending scoreboard (reserve on issue, clear on writeback) with a pending-count output;
- a selectable, registered display tap.

It sits between decode/issue (reads and reservations) and writeback (writes). The display tap feeds the board 7-seg/LED logic.

---
 rtl/regbank_scoreboard.sv | 153 +++++++++++++++
 tb/tb_regbank_scoreboard.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/regbank_scoreboard.sv
// regbank_scoreboard
//   Parametrised register bank with a per-register pending scoreboard and a
//   registered display tap. Decode/issue reads and reserves registers;
//   writeback writes them and clears their pending bit.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   rd_addr1/2            read addresses
//   rd_data1/2, rd_pend1/2  combinational read data and pending bits
//   wr_en/wr_addr/wr_data writeback port
//   rsv_en/rsv_addr       reservation request
//   rsv_ok                combinational: rsv_addr is free to reserve
//   pend_cnt              registered popcount of the pending bits
//   disp_addr/disp_data   display tap, low DISP_W bits, registered
//
// Optional build macro
//   REGBANK_BYPASS_EN : forward a same-cycle write to the read ports.

// One register plus its pending bit. The top decodes addresses into
// one-hot hit strobes so each entry only has to react to its own hits.
module regbank_entry #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_hit,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_hit,
  output logic [DATA_W-1:0] q,
  output logic              pend,
  output logic              pend_d
);

  // A reservation overrides a same-cycle clear from writeback.
  always_comb pend_d = rsv_hit | (pend & ~wr_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= INIT_VAL;
      pend <= 1'b0;
    end else begin
      if (wr_hit) q <= wr_data;
      pend <= pend_d;
    end
  end

endmodule

module regbank_scoreboard #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int DISP_W    = 16,
  parameter int INIT_STEP = 10,
  parameter int ZERO_REG  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_pend1,
  output logic              rd_pend2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  output logic [ADDR_W:0]   pend_cnt,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DISP_W-1:0] disp_data
);

  localparam int CNT_W = ADDR_W + 1;
  localparam bit HZ    = (ZERO_REG != 0);

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             pend_q;
  logic [DEPTH-1:0]             pend_d;
  logic [DEPTH-1:0]             wr_hit;
  logic [DEPTH-1:0]             rsv_hit;
  logic [CNT_W-1:0]             cnt_d;

  // R0 never holds a pending bit when hardwired, so the plain lookup
  // already reports it as free.
  always_comb rsv_ok = ~pend_q[rsv_addr] | (HZ && (rsv_addr == '0));

  // R0 is never hit when hardwired: it resets to 0*INIT_STEP and stays 0.
  // A reserve that collides with a same-address write still lands even
  // though rsv_ok (pre-edge view) may be low, so the write cannot free a
  // register that issue is trying to claim in the same cycle.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    localparam logic [ADDR_W-1:0] IDX  = ADDR_W'(i);
    localparam bit                LIVE = !(HZ && (i == 0));
    localparam logic [DATA_W-1:0] INIT = DATA_W'(longint'(i) * longint'(INIT_STEP));

    assign wr_hit[i]  = LIVE && wr_en && (wr_addr == IDX);
    assign rsv_hit[i] = LIVE && rsv_en && (rsv_addr == IDX) && (rsv_ok || wr_hit[i]);

    regbank_entry #(
      .DATA_W   (DATA_W),
      .INIT_VAL (INIT)
    ) u_ent (
      .clk     (clk),
      .rst     (rst),
      .wr_hit  (wr_hit[i]),
      .wr_data (wr_data),
      .rsv_hit (rsv_hit[i]),
      .q       (regs[i]),
      .pend    (pend_q[i]),
      .pend_d  (pend_d[i])
    );
  end

  always_comb begin
    rd_data1 = regs[rd_addr1];
    rd_pend1 = pend_q[rd_addr1];
    rd_data2 = regs[rd_addr2];
    rd_pend2 = pend_q[rd_addr2];
`ifdef REGBANK_BYPASS_EN
    if (wr_en && (wr_addr == rd_addr1) && !(HZ && (rd_addr1 == '0))) begin
      rd_data1 = wr_data;
      rd_pend1 = 1'b0;
    end
    if (wr_en && (wr_addr == rd_addr2) && !(HZ && (rd_addr2 == '0))) begin
      rd_data2 = wr_data;
      rd_pend2 = 1'b0;
    end
`endif
  end

  // Count from next-state bits so pend_cnt tracks the array exactly,
  // including reset and write/reserve collisions.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + CNT_W'(pend_d[i]);
  end

  // Display samples the pre-write array: write-to-display is two edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cnt  <= '0;
      disp_data <= '0;
    end else begin
      pend_cnt  <= cnt_d;
      disp_data <= regs[disp_addr][DISP_W-1:0];
    end
  end

endmodule

// File: tb/tb_regbank_scoreboard.sv
module tb_regbank_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd_addr1, rd_addr2, wr_addr, rsv_addr, disp_addr;
  logic [31:0] rd_data1, rd_data2, wr_data;
  logic        rd_pend1, rd_pend2, wr_en, rsv_en, rsv_ok;
  logic [4:0]  pend_cnt;
  logic [15:0] disp_data;

  regbank_scoreboard dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_pend1(rd_pend1), .rd_pend2(rd_pend2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .pend_cnt(pend_cnt),
    .disp_addr(disp_addr), .disp_data(disp_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference state
  logic [31:0] mreg [16];
  bit          mpend[16];
  logic [15:0] mdisp;
  int          mcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 16; i++) begin
      mreg[i]  = 32'(i * 10);
      mpend[i] = 1'b0;
    end
    mdisp = '0;
    mcnt  = 0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    if (a == 0) return '0;
`ifdef REGBANK_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
`endif
    return mreg[a];
  endfunction

  function automatic logic exp_pend(input logic [3:0] a);
    if (a == 0) return 1'b0;
`ifdef REGBANK_BYPASS_EN
    if (wr_en && wr_addr == a) return 1'b0;
`endif
    return mpend[a];
  endfunction

  // One clock: drive at negedge, check read side, then apply the rules
  // to the model at posedge and check the registered outputs.
  task automatic step(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                      input logic re, input logic [3:0] ra,
                      input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] da);
    bit ok;
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra;
    rd_addr1 = a1; rd_addr2 = a2; disp_addr = da;
    #1;
    chk("rd_data1", rd_data1, exp_rd(a1));
    chk("rd_data2", rd_data2, exp_rd(a2));
    chk("rd_pend1", 32'(rd_pend1), 32'(exp_pend(a1)));
    chk("rd_pend2", 32'(rd_pend2), 32'(exp_pend(a2)));
    ok = (ra == 0) || !mpend[ra];
    chk("rsv_ok", 32'(rsv_ok), 32'(ok));
    @(posedge clk);
    mdisp = mreg[da][15:0];
    if (we && wa != 0) begin
      mreg[wa]  = wd;
      mpend[wa] = 1'b0;
    end
    if (re && ra != 0 && (ok || (we && wa == ra))) mpend[ra] = 1'b1;
    mcnt = 0;
    for (int i = 0; i < 16; i++) mcnt += int'(mpend[i]);
    #1;
    chk("pend_cnt", 32'(pend_cnt), 32'(mcnt));
    chk("disp_data", 32'(disp_data), 32'(mdisp));
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 0; wr_addr = 0; wr_data = 0; rsv_en = 0; rsv_addr = 0;
    rd_addr1 = 4'd3; rd_addr2 = 4'd15; disp_addr = 0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_r3", rd_data1, 32'd30);
    chk("rst_r15", rd_data2, 32'd150);
    chk("rst_cnt", 32'(pend_cnt), 32'd0);
    chk("rst_disp", 32'(disp_data), 32'd0);
    rd_addr1 = 4'd0;
    #1;
    chk("rst_r0", rd_data1, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // mid-cycle asynchronous reset
    step(1, 5, 32'hDEAD, 0, 0, 5, 0, 0);
    @(negedge clk);
    wr_en = 0; rsv_en = 0; rd_addr1 = 5;
    #1;
    chk("pre_arst_r5", rd_data1, 32'hDEAD);
    #1 rst = 1'b1;
    #1;
    chk("arst_r5", rd_data1, 32'd50);
    rst = 1'b0;
    mdl_reset();
    chk("arst_cnt", 32'(pend_cnt), 32'd0);
    @(posedge clk);
    mdisp = mreg[disp_addr][15:0];

    // reserve / retry / writeback on R4
    step(0, 0, 0, 1, 4, 4, 4, 0);
    step(0, 0, 0, 1, 4, 4, 0, 0);
    chk("r4_cnt_hold", 32'(pend_cnt), 32'd1);
    step(1, 4, 32'h1234, 0, 0, 4, 0, 4);
    step(0, 0, 0, 0, 0, 4, 4, 4);
    chk("r4_data", rd_data1, 32'h1234);

    // R7 pending, then same-cycle write + reserve
    step(0, 0, 0, 1, 7, 7, 0, 0);
    step(1, 7, 32'hAAAA55, 1, 7, 7, 7, 7);
    step(0, 0, 0, 0, 0, 7, 7, 7);
    chk("r7_pend", 32'(rd_pend1), 32'd1);
    step(1, 7, 32'h7, 0, 0, 7, 0, 0);

    // hardwired R0
    step(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_cnt", 32'(pend_cnt), 32'd0);

    // forwarding / display latency on R9
    step(1, 9, 32'hCAFE, 0, 0, 9, 9, 9);
    step(0, 0, 0, 0, 0, 9, 0, 9);
    chk("r9_disp", 32'(disp_data), 32'hCAFE);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), $urandom,
           1'($urandom_range(0, 1)), 4'($urandom),
           4'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
